// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the dual-master AXI arbiter.
// Holds the channel FSM state encoding and the master index constants.
package axi_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int SERV0       = 0;
  localparam int SERV1       = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_arb_channel_fsm.sv
// One arbitration channel: IDLE -> ADDR -> RESP with round-robin pointer,
// watchdog abort and per-master saturating completion counters.
module axi_arb_channel_fsm
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MASTERS-1:0]       req,
  input  logic                         addr_ready,
  input  logic                         resp_done,
  output logic [NUM_MASTERS-1:0]       grant,
  output logic                         sel,
  output logic                         timeout,
  output logic [2*CNT_WIDTH-1:0]       count,
  output logic [1:0]                   state
);

  localparam int WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  arb_state_t             r_state;
  logic                   r_ptr;
  logic                   r_sel;
  logic                   r_timeout;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [WD_W-1:0]        r_wd;
  logic [CNT_WIDTH-1:0]   r_cnt [NUM_MASTERS];

  logic w_winner;
  logic w_expire;

  // Pointer master wins if it requests, otherwise the other requester.
  assign w_winner = req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_wd == WD_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_sel     <= 1'b0;
      r_timeout <= 1'b0;
      r_grant   <= '0;
      r_wd      <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_cnt[i] <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wd <= '0;
          if (|req) begin
            r_state <= ADDR;
            r_sel   <= w_winner;
            r_grant <= onehot(w_winner);
          end
        end
        ADDR, RESP: begin
          if (w_expire) begin
            // Abort still rotates priority so a stuck master cannot starve the other.
            r_timeout <= 1'b1;
            r_grant   <= '0;
            r_state   <= IDLE;
            r_wd      <= '0;
            r_ptr     <= ~r_sel;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (r_state == ADDR && addr_ready) begin
              r_state <= RESP;
              r_ptr   <= ~r_sel;
            end else if (r_state == RESP && resp_done) begin
              if (r_cnt[r_sel] != CNT_MAX) r_cnt[r_sel] <= r_cnt[r_sel] + 1'b1;
              r_state <= IDLE;
              r_grant <= '0;
              r_wd    <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign timeout = r_timeout;
  assign state   = r_state;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_cnt
    assign count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

endmodule

// File: rtl/axi_dual_master_arbiter.sv
// Control-only arbiter sharing one AXI slave between serv0 and serv1; drives
// the interconnect mux selects with independent read and write channels.
module axi_dual_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [1:0]             m_arvalid,
  input  logic                   s_arready,
  input  logic                   s_rdone,
  input  logic [1:0]             m_awvalid,
  input  logic                   s_awready,
  input  logic                   s_bdone,
  output logic [1:0]             rd_grant,
  output logic                   rd_sel,
  output logic [1:0]             wr_grant,
  output logic                   wr_sel,
  output logic                   rd_timeout,
  output logic                   wr_timeout,
  output logic [2*CNT_WIDTH-1:0] rd_count,
  output logic [2*CNT_WIDTH-1:0] wr_count,
  output logic [1:0]             rd_state,
  output logic [1:0]             wr_state
);

  // Handshake: the address phase completes on the cycle the slave ready is
  // high while a grant is held; the response phase completes on the done pulse
  // (RVALID&RREADY&RLAST or BVALID&BREADY) and the grant drops on the next edge.
  axi_arb_channel_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_rd_fsm (
    .clk        (ACLK),
    .rst        (ARESET),
    .req        (m_arvalid),
    .addr_ready (s_arready),
    .resp_done  (s_rdone),
    .grant      (rd_grant),
    .sel        (rd_sel),
    .timeout    (rd_timeout),
    .count      (rd_count),
    .state      (rd_state)
  );

  axi_arb_channel_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_wr_fsm (
    .clk        (ACLK),
    .rst        (ARESET),
    .req        (m_awvalid),
    .addr_ready (s_awready),
    .resp_done  (s_bdone),
    .grant      (wr_grant),
    .sel        (wr_sel),
    .timeout    (wr_timeout),
    .count      (wr_count),
    .state      (wr_state)
  );

endmodule

// File: tb/tb_axi_dual_master_arbiter.sv
// Directed bench for axi_dual_master_arbiter with short timeout and 2-bit counters.
`timescale 1ns/1ps
module tb_axi_dual_master_arbiter;

  localparam int CW = 2;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [1:0]    m_arvalid, m_awvalid;
  logic          s_arready, s_rdone, s_awready, s_bdone;
  logic [1:0]    rd_grant, wr_grant, rd_state, wr_state;
  logic          rd_sel, wr_sel, rd_timeout, wr_timeout;
  logic [2*CW-1:0] rd_count, wr_count;

  int checks = 0;
  int failures = 0;

  axi_dual_master_arbiter #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_arvalid(m_arvalid), .s_arready(s_arready), .s_rdone(s_rdone),
    .m_awvalid(m_awvalid), .s_awready(s_awready), .s_bdone(s_bdone),
    .rd_grant(rd_grant), .rd_sel(rd_sel), .wr_grant(wr_grant), .wr_sel(wr_sel),
    .rd_timeout(rd_timeout), .wr_timeout(wr_timeout),
    .rd_count(rd_count), .wr_count(wr_count),
    .rd_state(rd_state), .wr_state(wr_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs;
    m_arvalid = 2'b00; m_awvalid = 2'b00;
    s_arready = 1'b0;  s_rdone   = 1'b0;
    s_awready = 1'b0;  s_bdone   = 1'b0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    ARESET = 1'b1;
    m_arvalid = 2'b11; m_awvalid = 2'b11; s_rdone = 1'b1; s_bdone = 1'b1;
    tick();
    tick();
    checks++; if ({rd_grant, wr_grant} !== 4'b0000) begin failures++; $display("FAIL reset_grants_held got=%b exp=0000", {rd_grant, wr_grant}); end
    clear_inputs();
    ARESET = 1'b0;
    checks++; if ({rd_sel, wr_sel} !== 2'b00) begin failures++; $display("FAIL reset_sel got=%b exp=00", {rd_sel, wr_sel}); end
    checks++; if ({rd_timeout, wr_timeout} !== 2'b00) begin failures++; $display("FAIL reset_timeout got=%b exp=00", {rd_timeout, wr_timeout}); end
    checks++; if ({rd_count, wr_count} !== 8'h00) begin failures++; $display("FAIL reset_counts got=%h exp=00", {rd_count, wr_count}); end
    checks++; if ({rd_state, wr_state} !== 4'b0000) begin failures++; $display("FAIL reset_state got=%b exp=0000", {rd_state, wr_state}); end
  endtask

  task automatic test_single;
    apply_reset();
    m_arvalid = 2'b01;
    tick();
    checks++; if (rd_grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", rd_grant); end
    checks++; if (rd_sel !== 1'b0) begin failures++; $display("FAIL single_sel got=%b exp=0", rd_sel); end
    tick();
    checks++; if (rd_state !== 2'd1) begin failures++; $display("FAIL single_addr_wait got=%0d exp=1", rd_state); end
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid = 2'b00;
    checks++; if (rd_state !== 2'd2) begin failures++; $display("FAIL single_resp_state got=%0d exp=2", rd_state); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_grant !== 2'b01) begin failures++; $display("FAIL single_grant_hold cyc=%0d got=%b exp=01", i, rd_grant); end
    end
    s_rdone = 1'b1;
    tick();
    s_rdone = 1'b0;
    checks++; if (rd_grant !== 2'b00) begin failures++; $display("FAIL single_grant_release got=%b exp=00", rd_grant); end
    checks++; if (rd_count !== 4'b0001) begin failures++; $display("FAIL single_count got=%b exp=0001", rd_count); end
    s_rdone = 1'b1;
    tick();
    s_rdone = 1'b0;
    tick();
    checks++; if (rd_count !== 4'b0001) begin failures++; $display("FAIL stray_rdone_count got=%b exp=0001", rd_count); end
  endtask

  task automatic test_alternate;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    m_arvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_grant !== exp_g[i]) begin failures++; $display("FAIL alt_grant idx=%0d got=%b exp=%b", i, rd_grant, exp_g[i]); end
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0; s_rdone = 1'b1;
      tick();
      s_rdone = 1'b0;
      checks++; if (rd_grant !== 2'b00) begin failures++; $display("FAIL alt_idle_gap idx=%0d got=%b exp=00", i, rd_grant); end
    end
    m_arvalid = 2'b00;
    checks++; if (rd_count !== 4'b1010) begin failures++; $display("FAIL alt_counts got=%b exp=1010", rd_count); end
  endtask

  task automatic test_contention;
    apply_reset();
    m_arvalid = 2'b01;
    tick();
    checks++; if (rd_grant !== 2'b01) begin failures++; $display("FAIL cont_first got=%b exp=01", rd_grant); end
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid = 2'b11;
    tick();
    checks++; if (rd_grant !== 2'b01) begin failures++; $display("FAIL cont_hold got=%b exp=01", rd_grant); end
    s_rdone = 1'b1;
    tick();
    s_rdone = 1'b0;
    tick();
    checks++; if (rd_grant !== 2'b10) begin failures++; $display("FAIL cont_m1_wins got=%b exp=10", rd_grant); end
    checks++; if (rd_sel !== 1'b1) begin failures++; $display("FAIL cont_m1_sel got=%b exp=1", rd_sel); end
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; s_rdone = 1'b1;
    tick();
    s_rdone = 1'b0;
    tick();
    checks++; if (rd_grant !== 2'b01) begin failures++; $display("FAIL cont_m0_next got=%b exp=01", rd_grant); end
    m_arvalid = 2'b00; s_arready = 1'b1;
    tick();
    s_arready = 1'b0; s_rdone = 1'b1;
    tick();
    s_rdone = 1'b0;
    checks++; if (rd_count !== 4'b0110) begin failures++; $display("FAIL cont_counts got=%b exp=0110", rd_count); end
  endtask

  task automatic test_timeout;
    int early_pulses;
    early_pulses = 0;
    apply_reset();
    m_arvalid = 2'b01;
    tick();
    checks++; if (rd_grant !== 2'b01) begin failures++; $display("FAIL to_grant got=%b exp=01", rd_grant); end
    s_arready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      s_arready = 1'b0; m_arvalid = 2'b00;
      if (rd_timeout !== 1'b0 || rd_grant !== 2'b01) early_pulses++;
    end
    checks++; if (early_pulses !== 0) begin failures++; $display("FAIL to_early_abort got=%0d exp=0", early_pulses); end
    tick();
    checks++; if (rd_timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", rd_timeout); end
    checks++; if (rd_grant !== 2'b00) begin failures++; $display("FAIL to_grant_drop got=%b exp=00", rd_grant); end
    checks++; if (rd_count !== 4'b0000) begin failures++; $display("FAIL to_count got=%b exp=0000", rd_count); end
    m_arvalid = 2'b11;
    tick();
    checks++; if (rd_timeout !== 1'b0) begin failures++; $display("FAIL to_single_pulse got=%b exp=0", rd_timeout); end
    checks++; if (rd_grant !== 2'b10) begin failures++; $display("FAIL to_ptr_advance got=%b exp=10", rd_grant); end
    m_arvalid = 2'b00;
  endtask

  task automatic test_parallel_reset;
    apply_reset();
    m_arvalid = 2'b01; m_awvalid = 2'b10;
    tick();
    checks++; if ({rd_grant, wr_grant} !== 4'b0110) begin failures++; $display("FAIL par_grants got=%b exp=0110", {rd_grant, wr_grant}); end
    checks++; if ({rd_sel, wr_sel} !== 2'b01) begin failures++; $display("FAIL par_sels got=%b exp=01", {rd_sel, wr_sel}); end
    s_arready = 1'b1; s_awready = 1'b1;
    tick();
    s_arready = 1'b0; s_awready = 1'b0; m_arvalid = 2'b00; m_awvalid = 2'b00;
    s_bdone = 1'b1;
    tick();
    s_bdone = 1'b0;
    checks++; if (wr_count !== 4'b0100) begin failures++; $display("FAIL par_wr_count got=%b exp=0100", wr_count); end
    checks++; if (rd_grant !== 2'b01) begin failures++; $display("FAIL par_rd_in_resp got=%b exp=01", rd_grant); end
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    checks++; if ({rd_grant, wr_grant} !== 4'b0000) begin failures++; $display("FAIL par_reset_grants got=%b exp=0000", {rd_grant, wr_grant}); end
    checks++; if ({rd_count, wr_count} !== 8'h00) begin failures++; $display("FAIL par_reset_counts got=%h exp=00", {rd_count, wr_count}); end
  endtask

  task automatic test_saturation;
    logic [3:0] exp_cnt;
    int sat;
    apply_reset();
    for (int n = 1; n <= 5; n++) begin
      m_awvalid = 2'b10;
      tick();
      checks++; if (wr_grant !== 2'b10 || wr_sel !== 1'b1) begin failures++; $display("FAIL sat_grant n=%0d got=%b/%b exp=10/1", n, wr_grant, wr_sel); end
      s_awready = 1'b1;
      tick();
      s_awready = 1'b0; m_awvalid = 2'b00; s_bdone = 1'b1;
      tick();
      s_bdone = 1'b0;
      sat = (n > 3) ? 3 : n;
      exp_cnt = 4'(sat << 2);
      checks++; if (wr_count !== exp_cnt) begin failures++; $display("FAIL sat_count n=%0d got=%b exp=%b", n, wr_count, exp_cnt); end
    end
  endtask

  initial begin
    clear_inputs();
    ARESET = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_contention();
    test_timeout();
    test_parallel_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
